pe_array_sequencer: RTL and testbench

Phase sequencer for the binary PE array: after a single start pulse, it drives the array's weight-load, convolution and pop controls for one output tile. For each input channel it loads weights, then convolves. Once every input channel has accumulated, it pops all O_CH partial-sum rows out to the host. It sits between the host/test interface and the PE array and owns every array control strobe; data_in itself bypasses this block.

---
 rtl/pe_array_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pe_array_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sequencer.sv
// Phase sequencer for the binary PE array. One start pulse runs one output
// tile: for each input channel a weight load followed by a convolution pass,
// then every output-channel partial-sum row is popped out to the host.
//
// Handshake: start_in is a one-cycle request. It is taken only in IDLE, and
// only when num_ich_in is nonzero. There is no back-pressure anywhere. While
// data_req_out is high the host must present valid array data on that same
// cycle. While out_valid_out is high the host must take the psum row named by
// out_ch_out on that same cycle.
module pe_array_sequencer #(
  parameter int O_CH           = 64,
  parameter int OUT_ROW_LENGTH = 10,
  parameter int ICH_W          = 8,
  parameter int OCH_W          = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [ICH_W-1:0] num_ich_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             data_req_out,
  output logic             load_weight_out,
  output logic             conv_out,
  output logic             pop_out,
  output logic             out_valid_out,
  output logic [OCH_W-1:0] out_ch_out,
  output logic [ICH_W-1:0] ich_idx_out,
  output logic [2:0]       dbg_state_out
);

  localparam int CNT_MAX = (O_CH > OUT_ROW_LENGTH) ? O_CH : OUT_ROW_LENGTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(O_CH - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(OUT_ROW_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_CONV   = 3'd2,
    S_POP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ICH_W-1:0] r_ich;
  logic [ICH_W-1:0] w_ich_nxt;
  logic [ICH_W-1:0] r_num;
  logic [ICH_W-1:0] w_num_nxt;

  logic             r_busy;
  logic             r_done;
  logic             r_data_req;
  logic             r_load;
  logic             r_conv;
  logic             r_pop;
  logic [OCH_W-1:0] r_out_ch;
  logic [ICH_W-1:0] r_ich_out;

  // Next-state and counter logic. The counter restarts at 0 on every phase change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ich_nxt   = r_ich;
    w_num_nxt   = r_num;
    case (r_state)
      S_IDLE: begin
        if (start_in && (num_ich_in != '0)) begin
          w_state_nxt = S_LOAD_W;
          w_cnt_nxt   = '0;
          w_ich_nxt   = '0;
          w_num_nxt   = num_ich_in;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_nxt = S_CONV;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CONV: begin
        if (r_cnt == CONV_LAST) begin
          w_cnt_nxt = '0;
          if (r_ich == (r_num - 1'b1)) begin
            w_state_nxt = S_POP;
          end else begin
            w_state_nxt = S_LOAD_W;
            w_ich_nxt   = r_ich + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_POP: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ich   <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ich   <= w_ich_nxt;
      r_num   <= w_num_nxt;
    end
  end

  // Output registers. They are decoded from the next state, so each strobe
  // lines up with the phase that the state register enters on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_req <= 1'b0;
      r_load     <= 1'b0;
      r_conv     <= 1'b0;
      r_pop      <= 1'b0;
      r_out_ch   <= '0;
      r_ich_out  <= '0;
    end else begin
      r_busy     <= (w_state_nxt == S_LOAD_W) || (w_state_nxt == S_CONV) ||
                    (w_state_nxt == S_POP);
      r_done     <= (w_state_nxt == S_DONE);
      r_data_req <= (w_state_nxt == S_LOAD_W) || (w_state_nxt == S_CONV);
      r_load     <= (w_state_nxt == S_LOAD_W);
      r_conv     <= (w_state_nxt == S_CONV);
      r_pop      <= (w_state_nxt == S_POP);
      r_out_ch   <= (w_state_nxt == S_POP) ? OCH_W'(w_cnt_nxt) : '0;
      r_ich_out  <= (w_state_nxt == S_IDLE) ? '0 : w_ich_nxt;
    end
  end

  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign data_req_out    = r_data_req;
  assign load_weight_out = r_load;
  assign conv_out        = r_conv;
  assign pop_out         = r_pop;
  assign out_valid_out   = r_pop;
  assign out_ch_out      = r_out_ch;
  assign ich_idx_out     = r_ich_out;
  assign dbg_state_out   = r_state;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Bench for pe_array_sequencer with O_CH=4 and OUT_ROW_LENGTH=3. Each accepted
// start pushes its full strobe schedule into exp_q. Each entry holds the
// strobe kind, the absolute cycle and one auxiliary field. The monitor pops
// one entry whenever a strobe or done_out is seen.
module tb_pe_array_sequencer;

  localparam int OC    = 4;
  localparam int RL    = 3;
  localparam int ICH_W = 8;
  localparam int OCH_W = 2;
  localparam int W     = 26;

  logic             clk;
  logic             rst_in;
  logic             start_in;
  logic [ICH_W-1:0] num_ich_in;
  logic             busy_out;
  logic             done_out;
  logic             data_req_out;
  logic             load_weight_out;
  logic             conv_out;
  logic             pop_out;
  logic             out_valid_out;
  logic [OCH_W-1:0] out_ch_out;
  logic [ICH_W-1:0] ich_idx_out;
  logic [2:0]       dbg_state_out;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int req_cnt = 0;
  int last_t = 0;

  pe_array_sequencer #(
    .O_CH(OC), .OUT_ROW_LENGTH(RL), .ICH_W(ICH_W), .OCH_W(OCH_W)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .num_ich_in(num_ich_in),
    .busy_out(busy_out), .done_out(done_out), .data_req_out(data_req_out),
    .load_weight_out(load_weight_out), .conv_out(conv_out), .pop_out(pop_out),
    .out_valid_out(out_valid_out), .out_ch_out(out_ch_out),
    .ich_idx_out(ich_idx_out), .dbg_state_out(dbg_state_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int c, input int aux);
    logic [1:0]  k2;
    logic [15:0] c16;
    logic [7:0]  a8;
    k2  = kind[1:0];
    c16 = c[15:0];
    a8  = aux[7:0];
    exp_q.push_back({k2, c16, a8});
  endfunction

  // Expected schedule of a start accepted at the edge that ends cycle t.
  // Only entries at or before cycle lim are pushed.
  function automatic void push_run(input int t, input int n, input int lim);
    int base;
    int p;
    for (int i = 0; i < n; i++) begin
      base = t + 1 + i * (OC + RL);
      for (int k = 0; k < OC; k++) if (base + k <= lim) push(0, base + k, i);
      for (int k = 0; k < RL; k++) if (base + OC + k <= lim) push(1, base + OC + k, i);
    end
    p = t + 1 + n * (OC + RL);
    for (int k = 0; k < OC; k++) if (p + k <= lim) push(2, p + k, k);
    if (p + OC <= lim) push(3, p + OC, n - 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_start(input int n, input bit accept, input int lim);
    start_in   = 1'b1;
    num_ich_in = n[ICH_W-1:0];
    last_t     = cyc;
    if (accept) push_run(cyc, n, lim);
    step();
    start_in   = 1'b0;
    num_ich_in = ICH_W'($urandom_range(0, 255));
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    req_cnt  = 0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    int          nstrobe;
    logic [1:0]  kind;
    logic [7:0]  aux;
    logic [15:0] c16;
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (busy_out) busy_cnt++;
    if (data_req_out) req_cnt++;
    nstrobe = int'(load_weight_out) + int'(conv_out) + int'(pop_out);
    if (nstrobe > 0 || done_out) begin
      if (nstrobe > 0) check("strobe_onehot", nstrobe, 1);
      kind = pop_out ? 2'd2 : conv_out ? 2'd1 : load_weight_out ? 2'd0 : 2'd3;
      aux  = pop_out ? 8'(out_ch_out) : ich_idx_out;
      c16  = cyc[15:0];
      obs  = {kind, c16, aux};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual={kind %0d cycle %0d aux %0d} required=none",
                 kind, cyc, aux);
      end else begin
        e = exp_q.pop_front();
        check("event{kind,cycle,aux}", obs, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_in     = 1'b1;
    start_in   = 1'b1;
    num_ich_in = 8'd3;
    repeat (2) @(posedge clk);
    step();
    check("rst_hold_state", dbg_state_out, 0);
    check("rst_hold_busy", busy_out, 0);
    rst_in   = 1'b0;
    start_in = 1'b0;
    step();
    check("reset_state", dbg_state_out, 0);
    check("reset_strobes", {busy_out, done_out, data_req_out, load_weight_out,
                            conv_out, pop_out, out_valid_out}, 0);
    check("reset_out_ch", out_ch_out, 0);
    check("reset_ich_idx", ich_idx_out, 0);
    repeat (3) step();
    check("idle_after_release", dbg_state_out, 0);

    // single channel, with a start in the DONE cycle, then back-to-back start
    clear_counts();
    pulse_start(1, 1'b1, 1 << 30);
    wait_until(last_t + 12);
    pulse_start(2, 1'b0, 0);
    pulse_start(1, 1'b1, 1 << 30);
    drain(60);
    check("single_busy_cycles_x2", busy_cnt, 22);
    check("single_req_cycles_x2", req_cnt, 14);

    // two channels
    clear_counts();
    pulse_start(2, 1'b1, 1 << 30);
    drain(60);
    check("two_ch_busy_cycles", busy_cnt, 18);
    check("two_ch_req_cycles", req_cnt, 14);
    check("two_ch_ich_idle", ich_idx_out, 0);

    // num_ich_in = 0 is ignored
    clear_counts();
    pulse_start(0, 1'b0, 0);
    repeat (5) step();
    check("zero_ich_busy", busy_cnt, 0);
    check("zero_ich_state", dbg_state_out, 0);

    // start during CONV is ignored
    clear_counts();
    pulse_start(1, 1'b1, 1 << 30);
    wait_until(last_t + 6);
    check("in_conv", conv_out, 1);
    pulse_start(5, 1'b0, 0);
    drain(60);
    check("conv_start_busy", busy_cnt, 11);

    // reset during the second LOAD_W
    clear_counts();
    pulse_start(2, 1'b1, cyc + 9);
    wait_until(last_t + 9);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("midrst_state", dbg_state_out, 0);
    check("midrst_strobes", {busy_out, done_out, data_req_out, load_weight_out,
                             conv_out, pop_out}, 0);
    check("midrst_ich_idx", ich_idx_out, 0);
    check("midrst_queue", exp_q.size(), 0);
    repeat (5) step();
    clear_counts();
    pulse_start(1, 1'b1, 1 << 30);
    drain(60);
    check("post_rst_busy", busy_cnt, 11);

    // random channel count
    n = $urandom_range(1, 8);
    clear_counts();
    pulse_start(n, 1'b1, 1 << 30);
    drain(200);
    check("rand_busy_cycles", busy_cnt, n * (OC + RL) + OC);
    check("rand_req_cycles", req_cnt, n * (OC + RL));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
